jts16_snd_mailbox: RTL

- Sound-CPU end of the main-to-sound command channel.
- The main CPU's 8255 drives a command byte on port A and strobes PC7 low (snd_irqn). This block captures the byte and raises a Z80 NMI.
- It presents the byte on the sound CPU's latch I/O read, then frees the slot and reports readiness back on PC6 (snd_ack).
- One clock domain; the block sits between the main PPI and the sound Z80 bus decoder.

---
 rtl/jts16_snd_mailbox.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/jts16_snd_mailbox.sv
// jts16_snd_mailbox: sound-CPU end of the main-to-sound command channel.
// Captures the byte the main 8255 drives on port A when PC7 (snd_irqn) falls,
// raises the Z80 NMI, presents the byte on the latch I/O read and reports
// readiness back on PC6 (snd_ack).
//
// Ports:
//   clk, rstn  - system clock, asynchronous active-low reset
//   snd_latch  - command byte from main PPI port A
//   snd_irqn   - main PPI PC7, falling edge = new command
//   snd_ack    - to main PPI PC6, high = ready for a new command
//   latch_cs   - high while the Z80 reads the latch port (multi-cycle level)
//   dout       - byte to the Z80 data bus (8'hff when not reading)
//   nmi_n      - Z80 NMI, active low
//   overrun    - sticky, a command was lost
//
// Build option: define JTS16_SNDLATCH_FIFO_EN for a 4-entry command FIFO
// instead of the single-entry latch.
module jts16_snd_mailbox #(
  parameter int unsigned NMI_GAP = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] snd_latch,
  input  logic       snd_irqn,
  output logic       snd_ack,
  input  logic       latch_cs,
  output logic [7:0] dout,
  output logic       nmi_n,
  output logic       overrun
);

  localparam int unsigned DW = 8;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_READ, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            irqn_q, cs_q;
  logic [DW-1:0]   dout_q;
  logic            nmi_q, ack_q, ovr_q;

  logic            cap_c, rend_c, rise_c, pop_c;
  logic            avail_c, drop_c, ack_d;
  logic [DW-1:0]   head_c;

  // Edge events against the once-registered inputs
  assign cap_c  = irqn_q & ~snd_irqn;
  assign rend_c = cs_q & ~latch_cs;
  assign rise_c = ~cs_q & latch_cs;
  // Only a read that the NMI handshake started may consume the head
  assign pop_c  = (state_q == ST_READ) & rend_c;

`ifdef JTS16_SNDLATCH_FIFO_EN
  localparam int unsigned DEPTH = 4;

  logic [DW-1:0] mem_q [DEPTH];
  logic [1:0]    wp_q, rp_q;
  logic [2:0]    cnt_q, cnt_d;
  logic          full_c, push_c;

  // A push while full is accepted only when a pop frees a slot in the same cycle
  assign full_c  = (cnt_q == 3'(DEPTH));
  assign push_c  = cap_c & (~full_c | pop_c);
  assign drop_c  = cap_c & full_c & ~pop_c;
  assign cnt_d   = cnt_q + 3'(push_c) - 3'(pop_c);
  assign avail_c = (cnt_q != 3'd0);
  assign head_c  = mem_q[rp_q];
  assign ack_d   = (cnt_d != 3'(DEPTH));

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_c) begin
        mem_q[wp_q] <= snd_latch;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop_c) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [DW-1:0] data_q;
  logic          pend_q, pend_d;

  // A capture alongside a pop refills the slot instead of overwriting it
  assign pend_d  = cap_c | (pend_q & ~pop_c);
  assign drop_c  = cap_c & pend_q & ~pop_c;
  assign avail_c = pend_q;
  assign head_c  = data_q;
  assign ack_d   = ~pend_d;

  // Single-entry latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      if (cap_c) data_q <= snd_latch;
      pend_q <= pend_d;
    end
  end
`endif

  // NMI handshake next state
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: if (avail_c && gap_q == '0) state_d = ST_PEND;
      ST_PEND: if (rise_c) state_d = ST_READ;
      ST_READ: begin
        if (rend_c) begin
          state_d = ST_GAP;
          gap_d   = GW'(NMI_GAP);
        end
      end
      ST_GAP: begin
        // Leaving when the decremented count hits zero keeps nmi_n high NMI_GAP cycles
        gap_d = gap_q - GW'(1);
        if (gap_d == '0) state_d = avail_c ? ST_PEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, edge history and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      irqn_q  <= 1'b1;
      cs_q    <= 1'b0;
      dout_q  <= 8'hff;
      nmi_q   <= 1'b1;
      ack_q   <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      irqn_q  <= snd_irqn;
      cs_q    <= latch_cs;
      dout_q  <= (latch_cs && (state_q == ST_PEND || state_q == ST_READ)) ? head_c : 8'hff;
      nmi_q   <= ~(state_d == ST_PEND || state_d == ST_READ);
      ack_q   <= ack_d;
      ovr_q   <= ovr_q | drop_c;
    end
  end

  assign dout    = dout_q;
  assign nmi_n   = nmi_q;
  assign snd_ack = ack_q;
  assign overrun = ovr_q;

endmodule
